// File: rtl/axi_lite_to_reg_xbar_pkg.sv
// Shared types for the AXI-Lite to regbus crossbar.
// FSM state enum, AXI response codes, a48_d32 bus structs.
package axi_lite_to_reg_xbar_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WRESP,
        RRESP
    } xbar_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef struct packed {
        logic [47:0] aw_addr;
        logic        aw_valid;
        logic [31:0] w_data;
        logic [3:0]  w_strb;
        logic        w_valid;
        logic        b_ready;
        logic [47:0] ar_addr;
        logic        ar_valid;
        logic        r_ready;
    } a48_d32_req_t;

    typedef struct packed {
        logic        aw_ready;
        logic        w_ready;
        logic [1:0]  b_resp;
        logic        b_valid;
        logic        ar_ready;
        logic [31:0] r_data;
        logic [1:0]  r_resp;
        logic        r_valid;
    } a48_d32_rsp_t;

    typedef struct packed {
        logic [47:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_a48_d32_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_a48_d32_rsp_t;

endpackage

// File: rtl/axi_lite_to_reg_xbar_timeout_cnt.sv
// Per-access watchdog: clr restarts, en counts idle ACCESS cycles.
// Ports: clk_i, rst_i, clr_i, en_i, expire_o (TimeoutCycles==0 => never).
module reg_xbar_timeout_cnt #(
    parameter int unsigned TimeoutCycles = 256
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned CW =
        (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [CW-1:0] Last =
        CW'((TimeoutCycles == 0) ? 0 : TimeoutCycles - 1);
    localparam bit Enabled = (TimeoutCycles != 0);

    logic [CW-1:0] cnt_q;
    logic          at_last;

    assign at_last  = (cnt_q == Last);
    // Expires in the cycle whose missing ready would make TimeoutCycles.
    assign expire_o = Enabled && en_i && at_last;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && !at_last) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/axi_lite_to_reg_xbar.sv
// AXI-Lite slave decoded onto NumChannels regbus masters, one at a time.
// Ports: clk_i, rst_i, axi_lite_req_i/rsp_o, reg_req_o/rsp_i[], busy_o, timeout_o, err_count_o.
module axi_lite_to_reg_xbar
    import axi_lite_to_reg_xbar_pkg::*;
#(
    parameter int unsigned          AddrWidth     = 48,
    parameter int unsigned          DataWidth     = 32,
    parameter int unsigned          NumChannels   = 4,
    parameter logic [AddrWidth-1:0] BaseAddr      = '0,
    parameter logic [AddrWidth-1:0] WindowSize    = 'h1000,
    parameter int unsigned          TimeoutCycles = 256,
    parameter int unsigned          CntWidth      = 16,
    parameter type axi_lite_req_t = a48_d32_req_t,
    parameter type axi_lite_rsp_t = a48_d32_rsp_t,
    parameter type reg_req_t      = reg_a48_d32_req_t,
    parameter type reg_rsp_t      = reg_a48_d32_rsp_t
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  axi_lite_req_t       axi_lite_req_i,
    output axi_lite_rsp_t       axi_lite_rsp_o,
    output reg_req_t            reg_req_o [NumChannels],
    input  reg_rsp_t            reg_rsp_i [NumChannels],
    output logic                busy_o,
    output logic                timeout_o,
    output logic [CntWidth-1:0] err_count_o
);

    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned IdxW =
        (NumChannels > 1) ? $clog2(NumChannels) : 1;
    localparam int unsigned WinBits = $clog2(WindowSize);
    localparam int unsigned AW1 = AddrWidth + 1;
    localparam logic [AddrWidth:0] Span =
        AW1'(NumChannels) * AW1'(WindowSize);

    if ((WindowSize == 0) || ((WindowSize & (WindowSize - 1)) != 0)) begin : g_chk_win
        $error("WindowSize must be a power of two");
    end
    if ((NumChannels < 1) || (NumChannels > 16)) begin : g_chk_nch
        $error("NumChannels must be in 1..16");
    end
    if ((DataWidth != 32) && (DataWidth != 64)) begin : g_chk_dw
        $error("DataWidth must be 32 or 64");
    end

    xbar_state_e          state_q, state_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [DataWidth-1:0] wdata_q, wdata_d;
    logic [StrbWidth-1:0] wstrb_q, wstrb_d;
    logic                 write_q, write_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic [1:0]           resp_q, resp_d;
    logic [DataWidth-1:0] rdata_q, rdata_d;
    logic                 prio_w_q, prio_w_d;
    logic [CntWidth-1:0]  err_q, err_d;

    logic                 wr_elig, rd_elig;
    logic                 grant_w, grant_r;
    logic [AddrWidth-1:0] req_addr, off;
    logic                 hit;
    logic                 sel_ready, sel_err;
    logic [DataWidth-1:0] sel_rdata;
    logic                 cnt_clr, cnt_en, cnt_expire;

    assign wr_elig  = axi_lite_req_i.aw_valid && axi_lite_req_i.w_valid;
    assign rd_elig  = axi_lite_req_i.ar_valid;
    assign grant_w  = (state_q == IDLE) && wr_elig && (!rd_elig || prio_w_q);
    assign grant_r  = (state_q == IDLE) && rd_elig && !grant_w;
    assign req_addr = grant_w ? axi_lite_req_i.aw_addr : axi_lite_req_i.ar_addr;
    assign off      = req_addr - BaseAddr;
    assign hit      = (req_addr >= BaseAddr) && ({1'b0, off} < Span);

    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NumChannels; i++) begin
            if (idx_q == IdxW'(i)) begin
                sel_ready = reg_rsp_i[i].ready;
                sel_err   = reg_rsp_i[i].error;
                sel_rdata = reg_rsp_i[i].rdata;
            end
        end
    end

    assign cnt_clr = grant_w || grant_r;
    assign cnt_en  = (state_q == ACCESS) && !sel_ready;

    reg_xbar_timeout_cnt #(
        .TimeoutCycles(TimeoutCycles)
    ) u_wdog (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (cnt_clr),
        .en_i    (cnt_en),
        .expire_o(cnt_expire)
    );

    always_comb begin
        for (int i = 0; i < NumChannels; i++) begin
            reg_req_o[i] = '0;
            if ((state_q == ACCESS) && (idx_q == IdxW'(i))) begin
                reg_req_o[i].addr  = addr_q;
                reg_req_o[i].write = write_q;
                reg_req_o[i].wdata = wdata_q;
                reg_req_o[i].wstrb = wstrb_q;
                reg_req_o[i].valid = 1'b1;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        wstrb_d        = wstrb_q;
        write_d        = write_q;
        idx_d          = idx_q;
        resp_d         = resp_q;
        rdata_d        = rdata_q;
        prio_w_d       = prio_w_q;
        err_d          = err_q;
        timeout_o      = 1'b0;
        axi_lite_rsp_o = '0;
        axi_lite_rsp_o.b_resp  = resp_q;
        axi_lite_rsp_o.r_resp  = resp_q;
        axi_lite_rsp_o.r_data  = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (grant_w || grant_r) begin
                    axi_lite_rsp_o.aw_ready = grant_w;
                    axi_lite_rsp_o.w_ready  = grant_w;
                    axi_lite_rsp_o.ar_ready = grant_r;
                    addr_d   = req_addr;
                    write_d  = grant_w;
                    wdata_d  = grant_w ? axi_lite_req_i.w_data : '0;
                    wstrb_d  = grant_w ? axi_lite_req_i.w_strb : '0;
                    idx_d    = IdxW'(off >> WinBits);
                    prio_w_d = !prio_w_q;
                    if (hit) begin
                        state_d = ACCESS;
                    end else begin
                        // Decode miss answers directly, no regbus cycle.
                        resp_d  = RESP_DECERR;
                        rdata_d = '0;
                        state_d = grant_w ? WRESP : RRESP;
                    end
                end
            end
            ACCESS: begin
                if (sel_ready) begin
                    rdata_d = sel_rdata;
                    resp_d  = sel_err ? RESP_SLVERR : RESP_OKAY;
                    state_d = write_q ? WRESP : RRESP;
                end else if (cnt_expire) begin
                    timeout_o = 1'b1;
                    resp_d    = RESP_SLVERR;
                    rdata_d   = '0;
                    state_d   = write_q ? WRESP : RRESP;
                end
            end
            WRESP: begin
                axi_lite_rsp_o.b_valid = 1'b1;
                if (axi_lite_req_i.b_ready) begin
                    if ((resp_q != RESP_OKAY) && (err_q != '1)) begin
                        err_d = err_q + 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            RRESP: begin
                axi_lite_rsp_o.r_valid = 1'b1;
                if (axi_lite_req_i.r_ready) begin
                    if ((resp_q != RESP_OKAY) && (err_q != '1)) begin
                        err_d = err_q + 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            write_q  <= 1'b0;
            idx_q    <= '0;
            resp_q   <= RESP_OKAY;
            rdata_q  <= '0;
            prio_w_q <= 1'b1;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            write_q  <= write_d;
            idx_q    <= idx_d;
            resp_q   <= resp_d;
            rdata_q  <= rdata_d;
            prio_w_q <= prio_w_d;
            err_q    <= err_d;
        end
    end

    assign busy_o      = (state_q != IDLE);
    assign err_count_o = err_q;

endmodule

// File: tb/tb_axi_lite_to_reg_xbar.sv
// Self-checking bench for axi_lite_to_reg_xbar.
// Directed plan steps plus random transactions against a transaction model.
module tb_axi_lite_to_reg_xbar;
    import axi_lite_to_reg_xbar_pkg::*;

    localparam int NCH = 4;
    localparam int TMO = 8;
    localparam logic [47:0] BASE = 48'h0;
    localparam logic [47:0] WIN  = 48'h1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    a48_d32_req_t     req;
    a48_d32_rsp_t     rsp;
    reg_a48_d32_req_t rreq [NCH];
    reg_a48_d32_rsp_t rrsp [NCH];
    logic             busy, tmo;
    logic [15:0]      errc;

    axi_lite_to_reg_xbar #(
        .AddrWidth(48), .DataWidth(32), .NumChannels(NCH),
        .BaseAddr(BASE), .WindowSize(WIN),
        .TimeoutCycles(TMO), .CntWidth(16)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .axi_lite_req_i(req), .axi_lite_rsp_o(rsp),
        .reg_req_o(rreq), .reg_rsp_i(rrsp),
        .busy_o(busy), .timeout_o(tmo), .err_count_o(errc)
    );

    int checks = 0;
    int errors = 0;

    // Regbus slave behaviour: ready on the dly-th valid cycle, 0 = never.
    int          dly [NCH];
    logic [31:0] rd  [NCH];
    logic        er  [NCH];
    int          vcnt [NCH];
    int          vcyc [NCH];
    int          tmo_cnt = 0;
    int          stab_err = 0;
    logic [47:0] cap_addr  [NCH];
    logic        cap_write [NCH];
    logic [31:0] cap_wdata [NCH];
    logic [3:0]  cap_wstrb [NCH];
    reg_a48_d32_req_t prev [NCH];

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            rrsp[c].rdata = rd[c];
            rrsp[c].error = er[c];
            rrsp[c].ready = rreq[c].valid && (dly[c] != 0)
                            && (vcnt[c] == dly[c] - 1);
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++) vcnt[c] <= 0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                vcnt[c] <= rreq[c].valid ? vcnt[c] + 1 : 0;
            end
        end
    end

    always @(posedge clk) begin
        if (tmo) tmo_cnt <= tmo_cnt + 1;
        for (int c = 0; c < NCH; c++) begin
            if (rreq[c].valid) vcyc[c] <= vcyc[c] + 1;
            if (rreq[c].valid && vcnt[c] != 0 && rreq[c] != prev[c])
                stab_err <= stab_err + 1;
            prev[c] <= rreq[c];
            if (rreq[c].valid && rrsp[c].ready) begin
                cap_addr[c]  <= rreq[c].addr;
                cap_write[c] <= rreq[c].write;
                cap_wdata[c] <= rreq[c].wdata;
                cap_wstrb[c] <= rreq[c].wstrb;
            end
        end
    end

    logic prio_w_m = 1'b1;
    int   errc_m   = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_txn(input bit is_w, input logic [47:0] addr,
                          input logic [31:0] data, input logic [3:0] strb);
        bit          hit;
        int          ch, exp_lat, vexp, texp, lat, n;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rd;
        int          v0 [NCH];
        int          t0;
        logic [1:0]  got_resp;
        logic [31:0] got_rd;
        hit = (addr >= BASE) && (addr < BASE + NCH * WIN);
        ch  = hit ? int'((addr - BASE) / WIN) : -1;
        texp = 0;
        if (!hit) begin
            exp_lat = 1; exp_resp = RESP_DECERR; exp_rd = 0; vexp = 0;
        end else if (dly[ch] != 0 && dly[ch] <= TMO) begin
            exp_lat  = dly[ch] + 1;
            exp_resp = er[ch] ? RESP_SLVERR : RESP_OKAY;
            exp_rd   = rd[ch];
            vexp     = dly[ch];
        end else begin
            exp_lat = TMO + 1; exp_resp = RESP_SLVERR; exp_rd = 0;
            vexp = TMO; texp = 1;
        end
        for (int c = 0; c < NCH; c++) v0[c] = vcyc[c];
        t0 = tmo_cnt;
        if (is_w) begin
            req.aw_addr = addr; req.w_data = data; req.w_strb = strb;
            req.aw_valid = 1'b1; req.w_valid = 1'b1;
        end else begin
            req.ar_addr = addr; req.ar_valid = 1'b1;
        end
        n = 0;
        @(negedge clk);
        while (!(rsp.aw_ready || rsp.ar_ready) && n < 20) begin
            nxt(); @(negedge clk); n++;
        end
        chk("accept_cycle", n, 0);
        chk("aw_ready", rsp.aw_ready, is_w);
        chk("w_ready", rsp.w_ready, is_w);
        chk("ar_ready", rsp.ar_ready, !is_w);
        prio_w_m = !prio_w_m;
        nxt();
        req.aw_valid = 0; req.w_valid = 0; req.ar_valid = 0;
        req.b_ready = 1; req.r_ready = 1;
        lat = 1;
        @(negedge clk);
        while (!(is_w ? rsp.b_valid : rsp.r_valid) && lat < 40) begin
            nxt(); @(negedge clk); lat++;
        end
        got_resp = is_w ? rsp.b_resp : rsp.r_resp;
        got_rd   = rsp.r_data;
        chk("latency", lat, exp_lat);
        chk("resp", got_resp, exp_resp);
        if (!is_w) chk("rdata", got_rd, exp_rd);
        nxt();
        req.b_ready = 0; req.r_ready = 0;
        if (exp_resp != RESP_OKAY && errc_m != 16'hFFFF) errc_m++;
        chk("err_count", errc, errc_m);
        chk("busy_after", busy, 0);
        for (int c = 0; c < NCH; c++)
            chk("valid_cycles", vcyc[c] - v0[c], (c == ch) ? vexp : 0);
        chk("timeout_pulses", tmo_cnt - t0, texp);
        if (hit && texp == 0) begin
            chk("reg_addr", cap_addr[ch], addr);
            chk("reg_write", cap_write[ch], is_w);
            if (is_w) begin
                chk("reg_wdata", cap_wdata[ch], data);
                chk("reg_wstrb", cap_wstrb[ch], strb);
            end
        end
    endtask

    initial begin
        int          n;
        logic [31:0] held;
        req = '0;
        for (int c = 0; c < NCH; c++) begin
            dly[c] = 1; rd[c] = 0; er[c] = 0; vcyc[c] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_err", errc, 0);
        chk("rst_tmo", tmo, 0);
        chk("rst_rdy", {rsp.aw_ready, rsp.w_ready, rsp.ar_ready}, 0);
        chk("rst_rsp_v", {rsp.b_valid, rsp.r_valid}, 0);
        for (int c = 0; c < NCH; c++) chk("rst_reg_v", rreq[c].valid, 0);
        nxt();
        rst = 0;
        nxt();

        dly[1] = 3;
        do_txn(1, 48'h1004, 32'hCAFEF00D, 4'hF);
        dly[3] = 2; rd[3] = 32'h12345678; er[3] = 1;
        do_txn(0, 48'h3010, 0, 0);
        chk("err_after_slverr", errc, 1);
        do_txn(0, 48'h4000, 0, 0);
        dly[0] = 0;
        do_txn(0, 48'h0000, 0, 0);
        dly[0] = 2; rd[0] = 32'hA5A5_0F0F;
        do_txn(0, 48'h0008, 0, 0);
        do_txn(1, 48'hFFFF_0000, 32'h1, 4'h1);

        // Simultaneous AW+W and AR, every accept is a new transaction.
        dly[2] = 1; er[2] = 0; rd[2] = $urandom;
        req.aw_addr = 48'h2000; req.w_data = $urandom; req.w_strb = 4'hF;
        req.ar_addr = 48'h2004;
        req.aw_valid = 1; req.w_valid = 1; req.ar_valid = 1;
        req.b_ready = 1; req.r_ready = 1;
        for (int g = 0; g < 4; g++) begin
            n = 0;
            @(negedge clk);
            while (!(rsp.aw_ready || rsp.ar_ready) && n < 20) begin
                nxt(); @(negedge clk); n++;
            end
            chk("arb_w", rsp.aw_ready, prio_w_m);
            chk("arb_r", rsp.ar_ready, !prio_w_m);
            chk("arb_pattern", rsp.aw_ready, (g % 2) == 0);
            prio_w_m = !prio_w_m;
            nxt();
        end
        req.ar_valid = 0; req.r_ready = 0;
        n = 0;
        @(negedge clk);
        while (!rsp.r_valid && n < 20) begin
            nxt(); @(negedge clk); n++;
        end
        held = rsp.r_data;
        chk("arb_rdata", held, rd[2]);
        chk("arb_rresp", rsp.r_resp, RESP_OKAY);
        for (int k = 0; k < 5; k++) begin
            nxt(); @(negedge clk);
            chk("hold_rvalid", rsp.r_valid, 1);
            chk("hold_rdata", rsp.r_data, held);
            chk("hold_no_accept", rsp.aw_ready || rsp.ar_ready, 0);
        end
        nxt();
        req.r_ready = 1;
        nxt();
        @(negedge clk);
        chk("post_hold_accept", rsp.aw_ready, 1);
        prio_w_m = !prio_w_m;
        nxt();
        req.aw_valid = 0; req.w_valid = 0; req.r_ready = 0;
        n = 0;
        @(negedge clk);
        while (!rsp.b_valid && n < 20) begin
            nxt(); @(negedge clk); n++;
        end
        chk("post_hold_b", rsp.b_resp, RESP_OKAY);
        nxt();
        req.b_ready = 0;

        for (int i = 0; i < 40; i++) begin
            int          ch;
            logic [47:0] a;
            ch = $urandom_range(0, 4);
            if (ch < 4) begin
                a = BASE + 48'(ch) * WIN + 48'($urandom_range(0, 1023) * 4);
                dly[ch] = $urandom_range(0, 8);
                er[ch]  = 1'($urandom_range(0, 1));
                rd[ch]  = $urandom;
            end else begin
                a = 48'h4000 + 48'($urandom_range(0, 65535));
            end
            do_txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom));
        end

        dly[0] = 0;
        req.ar_addr = 48'h0; req.ar_valid = 1;
        nxt();
        req.ar_valid = 0; req.r_ready = 1;
        nxt(); nxt();
        @(negedge clk);
        chk("pre_rst_valid", rreq[0].valid, 1);
        chk("pre_rst_busy", busy, 1);
        #2 rst = 1;
        #1;
        chk("arst_valid", rreq[0].valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_err", errc, 0);
        chk("arst_rvalid", rsp.r_valid, 0);
        errc_m = 0; prio_w_m = 1;
        nxt();
        rst = 0; req.r_ready = 0;
        nxt();
        dly[2] = 2; er[2] = 0;
        do_txn(1, 48'h2010, 32'h0BAD_BEEF, 4'h3);

        chk("stable_fields", stab_err, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

endmodule

// File: doc/axi_lite_to_reg_xbar.md
Name: axi_lite_to_reg_xbar

Overview:
- Parametrised successor to the single-channel AXI-Lite-to-regbus protocol converter.
- One AXI-Lite slave port is decoded onto NumChannels register-bus master ports, for example bootrom and the FLL blocks behind one bridge.
- Adds capabilities the single converter lacks: address-window decode, a per-access timeout watchdog, decode/timeout error responses and an error counter.
- Sits in the peripheral clock domain between the occamy_top AXI-Lite outputs and the regbus peripherals.

Parameters:
AddrWidth, 48, AXI-Lite and regbus address width
DataWidth, 32, data width; strobe width is DataWidth/8
NumChannels, 4, number of regbus master ports (1..16)
BaseAddr, 48'h0, base address of window 0
WindowSize, 48'h1000, per-channel window size; power of two
TimeoutCycles, 256, regbus cycles allowed before abort; 0 disables the watchdog
CntWidth, 16, width of err_count_o
axi_lite_req_t / axi_lite_rsp_t, -, AXI-Lite struct types
reg_req_t / reg_rsp_t, -, regbus struct types

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
axi_lite_req_i  in  axi_lite_req_t  AXI-Lite request (AW, W, B-ready, AR, R-ready)
axi_lite_rsp_o  out  axi_lite_rsp_t  AXI-Lite response
reg_req_o  out  NumChannels x reg_req_t  regbus requests
reg_rsp_i  in  NumChannels x reg_rsp_t  regbus responses
busy_o  out  1  FSM not in IDLE
timeout_o  out  1  one-cycle pulse when an access is aborted
err_count_o  out  CntWidth  saturating count of non-OKAY responses

Behaviour:
- Reset values: all outputs 0, all valid/ready signals 0, FSM in IDLE, err_count_o 0, priority flag selects write.
- States: IDLE, ACCESS, WRESP, RRESP.
  - Only one transaction is in flight at a time; no outstanding transactions.
- IDLE:
  - A write is eligible when aw_valid and w_valid are both high.
  - A read is eligible when ar_valid is high.
  - If both are eligible, the priority flag decides; the flag toggles after every grant, giving round-robin.
  - A write asserts aw_ready and w_ready in the same single cycle. A read asserts ar_ready for one cycle.
  - The accept cycle latches addr, wdata, wstrb and the write flag.
  - aw_ready, w_ready and ar_ready are 0 in every state except this accept cycle.
- Decode:
  - idx = (addr - BaseAddr) / WindowSize.
  - In range only when BaseAddr <= addr < BaseAddr + NumChannels*WindowSize.
  - Out of range: skip ACCESS and go to WRESP/RRESP with resp = DECERR (2'b11) and rdata = 0. No regbus activity occurs.
- ACCESS:
  - reg_req_o[idx].valid = 1 with latched addr (full address, not rebased), write, wdata, wstrb. All other channels stay 0.
  - Request fields are stable while valid is high.
  - On reg_rsp_i[idx].ready:
    - Capture rdata.
    - resp = SLVERR (2'b10) if error, else OKAY.
    - Go to WRESP or RRESP; valid drops the same cycle.
- Watchdog:
  - Counter clears on entry to ACCESS and increments each ACCESS cycle without ready.
  - Reaching TimeoutCycles without ready: drop valid, pulse timeout_o, resp = SLVERR, rdata = 0.
  - If ready and the timeout hit occur in the same cycle, ready wins (normal response, no timeout).
- WRESP / RRESP:
  - b_valid (resp) or r_valid (data, resp) is held stable until b_ready / r_ready, then the FSM returns to IDLE.
  - A new request can be accepted the cycle after the handshake.
- Latency: accept at cycle 0, regbus valid at cycle 1, ready at cycle k ≥ 1, B/R valid at cycle k+1. Decode error responds at cycle 1.
- err_count_o increments at the B/R handshake when resp ≠ OKAY and saturates at all-ones.
- busy_o = (state ≠ IDLE).
- Asynchronous reset mid-operation: returns everything to reset values immediately. A pending regbus valid drops; no response is generated.
- Static checks: WindowSize power of two, NumChannels ≥ 1, DataWidth ∈ {32, 64}.

Decomposition:
- occamy_pkg, or a local package: state enum, AXI resp encodings (OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11) and the a48_d32 axi_lite/reg typedefs already defined there.
- One sub-module, reg_xbar_timeout_cnt: watchdog counter with clear/enable/expire and TimeoutCycles == 0 bypass.
- Decode and FSM stay in the top module.

Test Plan:
- Write to 0x1004, data 0xCAFEF00D, strb 4'hF, channel 1 ready after 3 cycles -> reg_req_o[1] valid cycles 1–3 with addr 0x1004; B OKAY at cycle 4; other channels stay idle.
- Read 0x3010, channel 3 returns rdata 0x12345678 with error = 1 -> R data 0x12345678, resp SLVERR, err_count_o = 1.
- Read 0x4000 (out of range, NumChannels = 4) -> no regbus valid; R resp DECERR, rdata 0 at cycle 1.
- Read with channel 0 never ready, TimeoutCycles = 8 -> valid for 8 cycles, timeout_o pulse, R SLVERR, rdata 0; the next read to channel 0 then succeeds.
- AW+W and AR presented simultaneously, back-to-back, twice -> grants alternate W, R, W, R; r_ready held low for 5 cycles -> R stays stable and no new accept occurs.
- rst_i asserted during ACCESS -> reg_req_o valid and busy_o drop asynchronously, err_count_o = 0; after release a fresh write completes OKAY.
